serial_adder: RTL and testbench

Parametrised digit-serial adder/subtractor that succeeds our single-bit combinational full adder. It reuses the same sum/carry equations on a DIGIT-bit slice and holds the carry in a flip-flop between cycles. A WIDTH-bit operation takes WIDTH/DIGIT cycles. The block sits between valid/ready producer and consumer stages, in datapaths where area matters more than latency.

---
 rtl/serial_adder.sv | 243 ++++++++++++++++++++++++
 tb/tb_serial_adder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Digit-serial two's-complement adder/subtractor with valid/ready handshakes
// on both sides. A WIDTH-bit operation is split into WIDTH/DIGIT slices of
// DIGIT bits. One slice is added per clock through a small ripple-carry
// chain, and the carry is held in a flip-flop between slices. This trades
// latency for area. The per-bit sum and carry equations are the same ones our
// single-bit full adder uses.
//
// Subtraction reuses the adder. B is inverted at load time, and the carry
// register is seeded with carry_in ^ sub. This gives
//     a + ~b + !carry_in = a - b - carry_in.
// As a result, in subtract mode carry_out = 1 means "no borrow".
//
// Parameters
//   WIDTH : operand/result width in bits (>= 2)
//   DIGIT : bits processed per clock; WIDTH must be a multiple of DIGIT
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset; aborts any operation
//   in_valid   : a, b, carry_in and sub form a valid operand set
//   in_ready   : block is idle and will accept an operand set
//   a, b       : WIDTH-bit operands
//   carry_in   : carry into the LSB (add) or borrow into the LSB (sub)
//   sub        : 0 -> a + b + carry_in, 1 -> a - b - carry_in
//   out_valid  : sum / carry_out / overflow hold a finished result
//   out_ready  : consumer takes the result
//   sum        : result modulo 2^WIDTH
//   carry_out  : raw carry out of the MSB
//   overflow   : two's-complement signed overflow
//
// Operation: IDLE --accept--> RUN (WIDTH/DIGIT cycles) --> DONE --take--> IDLE.
// Only one operation is in flight at a time. in_valid is ignored outside IDLE.
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    // Number of slices per operation, and the width of the slice counter.
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Ripple-carry add of one DIGIT-bit slice.
    // Packed return value:
    //   [DIGIT+1]   carry into the slice's top bit (overflow detection)
    //   [DIGIT]     carry out of the slice
    //   [DIGIT-1:0] slice sum bits
    function automatic logic [DIGIT+1:0] digit_add(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             cin
    );
        logic [DIGIT-1:0] s;
        logic             c;
        logic             c_top;
        s     = {DIGIT{1'b0}};
        c     = cin;
        c_top = cin;
        for (int i = 0; i < DIGIT; i++) begin
            c_top = c;
            s[i]  = x[i] ^ y[i] ^ c;
            c     = ((x[i] ^ y[i]) & c) | (x[i] & y[i]);
        end
        return {c_top, c, s};
    endfunction

    // State and datapath registers
    logic [1:0]       state_r;
    logic [1:0]       state_next_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;

    // Registered outputs
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_out_r;
    logic             overflow_r;

    // Combinational helpers
    logic                   accept_s;
    logic                   take_s;
    logic                   last_s;
    logic [DIGIT+1:0]       digit_s;
    logic [DIGIT-1:0]       dsum_s;
    logic                   dcout_s;
    logic                   dctop_s;
    logic [WIDTH+DIGIT-1:0] res_cat_s;
    logic [WIDTH+DIGIT-1:0] res_shift_s;
    logic [WIDTH-1:0]       res_next_s;

    assign accept_s = in_valid & in_ready_r;
    assign take_s   = out_valid_r & out_ready;
    assign last_s   = (cnt_r == LAST_CNT);

    assign digit_s = digit_add(a_r[DIGIT-1:0], b_r[DIGIT-1:0], carry_r);
    assign dsum_s  = digit_s[DIGIT-1:0];
    assign dcout_s = digit_s[DIGIT];
    assign dctop_s = digit_s[DIGIT+1];

    // New slice bits enter at the MSB end and older bits move down.
    // Concatenating and then shifting keeps this legal even when DIGIT == WIDTH.
    assign res_cat_s   = {dsum_s, res_r};
    assign res_shift_s = res_cat_s >> DIGIT;
    assign res_next_s  = res_shift_s[WIDTH-1:0];

    // Next-state logic for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (take_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand load, per-slice shift and carry/counter update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r     <= a;
                        b_r     <= sub ? ~b : b;
                        carry_r <= carry_in ^ sub;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                ST_RUN: begin
                    a_r     <= a_r >> DIGIT;
                    b_r     <= b_r >> DIGIT;
                    res_r   <= res_next_s;
                    carry_r <= dcout_s;
                    cnt_r   <= cnt_r + CNT_ONE;
                end
                default: begin
                    cnt_r   <= cnt_r;
                end
            endcase
        end
    end

    // Result capture on the last slice. The outputs then hold until the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r       <= {WIDTH{1'b0}};
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else if ((state_r == ST_RUN) && last_s) begin
            sum_r       <= res_next_s;
            carry_out_r <= dcout_s;
            // The final slice's top bit is the word MSB.
            overflow_r  <= dctop_s ^ dcout_s;
        end else begin
            sum_r       <= sum_r;
            carry_out_r <= carry_out_r;
            overflow_r  <= overflow_r;
        end
    end

    // Handshake flags, decoded from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == ST_IDLE);
            out_valid_r <= (state_next_s == ST_DONE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign carry_out = carry_out_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Four WIDTH=8 instances (DIGIT = 1, 2, 4, 8) share one operand bus, and a
// WIDTH=16 / DIGIT=4 instance gets its own 16-bit operands. All five accept
// together. Each finishes after its own latency and then waits in DONE until
// the bench drains them.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int NI = 4;

    logic clk;
    logic rst_n;
    logic in_valid;
    logic out_ready;
    logic cin;
    logic sub;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] a16;
    logic [15:0] b16;

    logic [NI-1:0] in_ready_w;
    logic [NI-1:0] out_valid_w;
    logic [NI-1:0] cout_w;
    logic [NI-1:0] ovf_w;
    logic [7:0]    sum_w [NI];

    logic        in_ready16;
    logic        out_valid16;
    logic        cout16;
    logic        ovf16;
    logic [15:0] sum16;

    int tests;
    int fails;

    // Results captured on each instance's first out_valid cycle
    int          lat [NI];
    logic [7:0]  got_sum [NI];
    logic        got_c [NI];
    logic        got_o [NI];
    int          lat16;
    logic [15:0] got_sum16;
    logic        got_c16;
    logic        got_o16;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        serial_adder #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .a         (a),
            .b         (b),
            .carry_in  (cin),
            .sub       (sub),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .sum       (sum_w[g]),
            .carry_out (cout_w[g]),
            .overflow  (ovf_w[g])
        );
    end

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .carry_in  (cin),
        .sub       (sub),
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .sum       (sum16),
        .carry_out (cout16),
        .overflow  (ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept one operand set, then scramble the inputs during RUN.
    // Capture every instance's result and latency.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                          input logic tc, input logic ts,
                          input logic [15:0] ta16, input logic [15:0] tb16);
        @(negedge clk);
        a = ta; b = tb; cin = tc; sub = ts; a16 = ta16; b16 = tb16;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~ta; b = ~tb; cin = ~tc; sub = ~ts; a16 = ~ta16; b16 = ~tb16;
        for (int i = 0; i < NI; i++) lat[i] = -1;
        lat16 = -1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (lat[i] < 0 && out_valid_w[i]) begin
                    lat[i] = cyc; got_sum[i] = sum_w[i]; got_c[i] = cout_w[i]; got_o[i] = ovf_w[i];
                end
            end
            if (lat16 < 0 && out_valid16) begin
                lat16 = cyc; got_sum16 = sum16; got_c16 = cout16; got_o16 = ovf16;
            end
        end
    endtask

    // Release every instance from DONE back to IDLE.
    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NI; i++) begin
            tests++;
            if ({in_ready_w[i], out_valid_w[i], sum_w[i], cout_w[i], ovf_w[i]} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL reset_state d%0d: got rdy=%b vld=%b sum=%h c=%b o=%b, want rdy=1 vld=0 sum=00 c=0 o=0",
                         1 << i, in_ready_w[i], out_valid_w[i], sum_w[i], cout_w[i], ovf_w[i]);
            end
        end
    endtask

    task automatic test_add_wrap();
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < NI; i++) begin
            tests++;
            if ({got_sum[i], got_c[i], got_o[i]} !== {8'h00, 1'b1, 1'b0} || lat[i] != (8 >> i)) begin
                fails++;
                $display("FAIL add_wrap d%0d: got sum=%h c=%b o=%b lat=%0d, want sum=00 c=1 o=0 lat=%0d",
                         1 << i, got_sum[i], got_c[i], got_o[i], lat[i], 8 >> i);
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < NI; i++) begin
            tests++;
            if ({got_sum[i], got_c[i], got_o[i]} !== {8'h80, 1'b0, 1'b1} || lat[i] != (8 >> i)) begin
                fails++;
                $display("FAIL add_ovf d%0d: got sum=%h c=%b o=%b lat=%0d, want sum=80 c=0 o=1 lat=%0d",
                         1 << i, got_sum[i], got_c[i], got_o[i], lat[i], 8 >> i);
            end
        end
        drain();
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 16'h0000, 16'h0000);
        for (int i = 0; i < NI; i++) begin
            tests++;
            if ({got_sum[i], got_c[i], got_o[i]} !== {8'hFE, 1'b0, 1'b0} || lat[i] != (8 >> i)) begin
                fails++;
                $display("FAIL sub_borrow d%0d: got sum=%h c=%b o=%b lat=%0d, want sum=fe c=0 o=0 lat=%0d",
                         1 << i, got_sum[i], got_c[i], got_o[i], lat[i], 8 >> i);
            end
        end
        drain();
    endtask

    task automatic test_carry_in();
        run_op(8'h3C, 8'hC5, 1'b1, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < NI; i++) begin
            tests++;
            if ({got_sum[i], got_c[i], got_o[i]} !== {8'h02, 1'b1, 1'b0} || lat[i] != (8 >> i)) begin
                fails++;
                $display("FAIL carry_in d%0d: got sum=%h c=%b o=%b lat=%0d, want sum=02 c=1 o=0 lat=%0d",
                         1 << i, got_sum[i], got_c[i], got_o[i], lat[i], 8 >> i);
            end
        end
        drain();
        // 0x80 - 0x01: -128 - 1 overflows, no borrow
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 16'h0000, 16'h0000);
        for (int i = 0; i < NI; i++) begin
            tests++;
            if ({got_sum[i], got_c[i], got_o[i]} !== {8'h7F, 1'b1, 1'b1}) begin
                fails++;
                $display("FAIL sub_ovf d%0d: got sum=%h c=%b o=%b, want sum=7f c=1 o=1",
                         1 << i, got_sum[i], got_c[i], got_o[i]);
            end
        end
        drain();
        // 0 - 0 - borrow = 0xFF with borrow out
        run_op(8'h00, 8'h00, 1'b1, 1'b1, 16'h0000, 16'h0000);
        for (int i = 0; i < NI; i++) begin
            tests++;
            if ({got_sum[i], got_c[i], got_o[i]} !== {8'hFF, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL sub_borrow_in d%0d: got sum=%h c=%b o=%b, want sum=ff c=0 o=0",
                         1 << i, got_sum[i], got_c[i], got_o[i]);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = k[0];
            a = 8'hAA;
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                tests++;
                if ({out_valid_w[i], in_ready_w[i], sum_w[i]} !== {1'b1, 1'b0, 8'h46}) begin
                    fails++;
                    $display("FAIL backpressure d%0d cyc%0d: got vld=%b rdy=%b sum=%h, want vld=1 rdy=0 sum=46",
                             1 << i, k, out_valid_w[i], in_ready_w[i], sum_w[i]);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        // The in_valid pulses seen during DONE must not have started a new operation.
        for (int i = 0; i < NI; i++) begin
            tests++;
            if ({in_ready_w[i], out_valid_w[i]} !== {1'b1, 1'b0}) begin
                fails++;
                $display("FAIL release d%0d: got rdy=%b vld=%b, want rdy=1 vld=0",
                         1 << i, in_ready_w[i], out_valid_w[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            tests++;
            if ({in_ready_w[i], out_valid_w[i], sum_w[i]} !== {1'b1, 1'b0, 8'h00}) begin
                fails++;
                $display("FAIL mid_reset d%0d: got rdy=%b vld=%b sum=%h, want rdy=1 vld=0 sum=00",
                         1 << i, in_ready_w[i], out_valid_w[i], sum_w[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h10, 8'h20, 1'b0, 1'b0, 16'h1000, 16'h2000);
        for (int i = 0; i < NI; i++) begin
            tests++;
            if ({got_sum[i], got_c[i], got_o[i]} !== {8'h30, 1'b0, 1'b0} || lat[i] != (8 >> i)) begin
                fails++;
                $display("FAIL after_reset d%0d: got sum=%h c=%b o=%b lat=%0d, want sum=30 c=0 o=0 lat=%0d",
                         1 << i, got_sum[i], got_c[i], got_o[i], lat[i], 8 >> i);
            end
        end
        tests++;
        if ({got_sum16, got_c16, got_o16} !== {16'h3000, 1'b0, 1'b0} || lat16 != 4) begin
            fails++;
            $display("FAIL after_reset w16: got sum=%h c=%b o=%b lat=%0d, want sum=3000 c=0 o=0 lat=4",
                     got_sum16, got_c16, got_o16, lat16);
        end
        drain();
    endtask

    task automatic test_random();
        logic [7:0]  ra, rb, bb, es;
        logic [15:0] ra16, rb16, bb16, es16;
        logic        rc, rs, ci, ec, eo, ec16, eo16;
        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            ra16 = 16'($urandom); rb16 = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            bb = rs ? ~rb : rb;
            bb16 = rs ? ~rb16 : rb16;
            ci = rc ^ rs;
            {ec, es} = {1'b0, ra} + {1'b0, bb} + {8'h00, ci};
            eo = (ra[7] == bb[7]) && (es[7] != ra[7]);
            {ec16, es16} = {1'b0, ra16} + {1'b0, bb16} + {16'h0000, ci};
            eo16 = (ra16[15] == bb16[15]) && (es16[15] != ra16[15]);
            run_op(ra, rb, rc, rs, ra16, rb16);
            for (int i = 0; i < NI; i++) begin
                tests++;
                if ({got_sum[i], got_c[i], got_o[i]} !== {es, ec, eo} || lat[i] != (8 >> i)) begin
                    fails++;
                    $display("FAIL random d%0d a=%h b=%h ci=%b sub=%b: got sum=%h c=%b o=%b lat=%0d, want sum=%h c=%b o=%b lat=%0d",
                             1 << i, ra, rb, rc, rs, got_sum[i], got_c[i], got_o[i], lat[i], es, ec, eo, 8 >> i);
                end
            end
            tests++;
            if ({got_sum16, got_c16, got_o16} !== {es16, ec16, eo16} || lat16 != 4) begin
                fails++;
                $display("FAIL random w16 a=%h b=%h ci=%b sub=%b: got sum=%h c=%b o=%b lat=%0d, want sum=%h c=%b o=%b lat=4",
                         ra16, rb16, rc, rs, got_sum16, got_c16, got_o16, lat16, es16, ec16, eo16);
            end
            drain();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
        a16 = 16'h0000; b16 = 16'h0000;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_add_wrap();
        test_back_to_back();
        test_carry_in();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
